muladd_seq: RTL and testbench

//   Sequential shift-and-add multiply-accumulate computing y = q*b + r.

---
 rtl/muladd_seq.sv | 79 +++++++
 tb/tb_muladd_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/muladd_seq.sv
// Sequential shift-and-add multiply-accumulate: y = q*b + r, one quotient bit per clock.
// Rebuilds a divider's dividend from (quotient, divisor, remainder) to check the divider.
module muladd_seq #(
    parameter int width = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [width-1:0]   q,
    input  logic [width-1:0]   b,
    input  logic [width-1:0]   r,
    output logic               busy,
    output logic               done,
    output logic [2*width-1:0] y
);
    localparam int cw = (width > 1) ? $clog2(width) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [width-1:0]     q_reg, b_reg;
    logic [2*width-1:0]   acc, acc_sum, b_ext;
    logic [cw-1:0]        cnt;
    logic                 last;

    assign last  = (cnt == cw'(width - 1));
    assign b_ext = {{width{1'b0}}, b_reg};
    // Partial product for this bit; the final sum is what lands in y.
    assign acc_sum = q_reg[0] ? acc + (b_ext << cnt) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            y     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    q_reg <= q;
                    b_reg <= b;
                    acc   <= {{width{1'b0}}, r};
                    cnt   <= '0;
                end
                RUN: begin
                    acc   <= acc_sum;
                    q_reg <= q_reg >> 1;
                    cnt   <= cnt + cw'(1);
                    if (last) y <= acc_sum;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muladd_seq.sv
// Directed bench for muladd_seq: handshake timing, arithmetic corners, reset abort, divider round trip.
module tb_muladd_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  q, b, r;
    logic        busy, done;
    logic [11:0] y;

    int checks = 0;
    int errors = 0;

    muladd_seq #(.width(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .q(q), .b(b), .r(r),
        .busy(busy), .done(done), .y(y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE; operands are scrambled right after acceptance.
    task automatic do_op(input logic [5:0] qi, bi, ri, input logic [11:0] exp, input string tag);
        int e, nb;
        q = qi; b = bi; r = ri; start = 1'b1;
        tick();
        start = 1'b0;
        q = 6'($urandom_range(0, 63));
        b = 6'($urandom_range(0, 63));
        r = 6'($urandom_range(0, 63));
        e = 0; nb = 0;
        while (!done && e < 20) begin
            if (busy) nb++;
            tick();
            e++;
        end
        chk({tag, "_lat"}, e, 6);
        chk({tag, "_busy"}, nb, 6);
        chk({tag, "_y"}, y, exp);
        chk({tag, "_busy_in_done"}, busy, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_y_hold"}, y, exp);
    endtask

    initial begin
        logic [11:0] exp_q[$];
        int a;
        logic [5:0] bq;

        // Reset with start asserted: nothing should begin.
        rst_n = 1'b0; start = 1'b1; q = 6'd7; b = 6'd5; r = 6'd3;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_y", y, 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_y", y, 0);

        do_op(6'd7, 6'd5, 6'd3, 12'd38, "basic");
        do_op(6'd63, 6'd63, 6'd63, 12'd4032, "max");
        do_op(6'd0, 6'd41, 6'd17, 12'd17, "q0");
        do_op(6'd12, 6'd0, 6'd9, 12'd9, "b0");
        do_op(6'd0, 6'd0, 6'd0, 12'd0, "zero");

        // start held high: acceptances at edges 0, 8, 16; results at 6, 14, 22.
        for (int i = 0; i < 24; i++) begin
            start = (i < 20);
            q = 6'($urandom_range(0, 63));
            b = 6'($urandom_range(0, 63));
            r = 6'($urandom_range(0, 63));
            if (i % 8 == 0 && i < 20) exp_q.push_back(12'(q * b + r));
            tick();
            chk("b2b_busy", busy, (i % 8) < 6);
            chk("b2b_done", done, (i % 8) == 6);
            if (i % 8 == 6) chk("b2b_y", y, exp_q.pop_front());
        end
        start = 1'b0;
        tick();

        // Reset in the 3rd RUN cycle discards the op.
        q = 6'd9; b = 6'd7; r = 6'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_y", y, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) rst_n = 1'b1;
            tick();
            chk("abort_no_done", done, 0);
        end
        do_op(6'd9, 6'd7, 6'd2, 12'd65, "after_abort");

        // Divider round trip: a -> (a/b, a%b) -> y must equal a.
        for (int i = 0; i < 500; i++) begin
            bq = 6'($urandom_range(1, 63));
            a  = $urandom_range(0, 64 * int'(bq) - 1);
            do_op(6'(a / int'(bq)), bq, 6'(a % int'(bq)), 12'(a), "rt");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
